// File: rtl/sum_request_feeder_if.sv
// Signal bundle between the request source, the request feeder and the sum engine.
// The slave modport is the feeder's view; the master modport is the source/engine side.
interface sum_request_feeder_if #(
  parameter int AW = 2
);
  logic [7:0]  In_N;
  logic        In_valid;
  logic        In_ready;
  logic [7:0]  N_out;
  logic        N_valid_out;
  logic        Sum_valid_in;
  logic        Busy;
  logic        Zero_drop;
  logic [AW:0] Level;
  logic [15:0] Issued_cnt;

  modport master (
    output In_N, In_valid, Sum_valid_in,
    input  In_ready, N_out, N_valid_out, Busy, Zero_drop, Level, Issued_cnt
  );

  modport slave (
    input  In_N, In_valid, Sum_valid_in,
    output In_ready, N_out, N_valid_out, Busy, Zero_drop, Level, Issued_cnt
  );
endinterface

// File: rtl/sum_request_feeder.sv
// Request stage for the sum engine: buffers N values in a small FIFO and issues them
// one at a time, waiting for each result before sending the next. N=0 is discarded.
//
// state | meaning
// IDLE  | no request outstanding; pop the FIFO head when one is present
// ISSUE | N_valid_out is high for this single cycle
// WAIT  | request outstanding; hold N_out until Sum_valid_in returns
module sum_request_feeder #(
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic                Clk,
  input  logic                Rst_n,
  sum_request_feeder_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [7:0]    mem_q [DEPTH];
  logic [7:0]    mem_d [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   level_q, level_d;
  logic [7:0]    n_out_q, n_out_d;
  logic          n_valid_q, n_valid_d;
  logic          busy_q, busy_d;
  logic          zero_drop_q, zero_drop_d;
  logic [15:0]   issued_q, issued_d;

  logic          in_ready;
  logic          push;
  logic          pop;
  logic [7:0]    head;

  // Held low through reset so the source sees no room until the FIFO is live.
  assign in_ready = Rst_n && (level_q < (AW+1)'(DEPTH));

  always_comb begin
    state_d     = state_q;
    mem_d       = mem_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    level_d     = level_q;
    n_out_d     = n_out_q;
    n_valid_d   = n_valid_q;
    busy_d      = busy_q;
    zero_drop_d = zero_drop_q;
    issued_d    = issued_q;
    push        = bus.In_valid && in_ready;
    pop         = 1'b0;
    head        = mem_q[rd_ptr_q];

    case (state_q)
      IDLE: begin
        if (level_q != '0) begin
          pop = 1'b1;
          if (head == 8'd0) begin
            zero_drop_d = 1'b1;
          end else begin
            n_out_d   = head;
            n_valid_d = 1'b1;
            busy_d    = 1'b1;
            issued_d  = issued_q + 16'd1;
            state_d   = ISSUE;
          end
        end
      end
      ISSUE: begin
        n_valid_d = 1'b0;
        state_d   = WAIT;
      end
      WAIT: begin
        if (bus.Sum_valid_in) begin
          busy_d  = 1'b0;
          state_d = IDLE;
        end
      end
      default: begin
        n_valid_d = 1'b0;
        busy_d    = 1'b0;
        state_d   = IDLE;
      end
    endcase

    if (push) begin
      mem_d[wr_ptr_q] = bus.In_N;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    if (push && !pop) begin
      level_d = level_q + 1'b1;
    end else if (!push && pop) begin
      level_d = level_q - 1'b1;
    end
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q     <= IDLE;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      n_out_q     <= '0;
      n_valid_q   <= 1'b0;
      busy_q      <= 1'b0;
      zero_drop_q <= 1'b0;
      issued_q    <= '0;
    end else begin
      state_q     <= state_d;
      mem_q       <= mem_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      level_q     <= level_d;
      n_out_q     <= n_out_d;
      n_valid_q   <= n_valid_d;
      busy_q      <= busy_d;
      zero_drop_q <= zero_drop_d;
      issued_q    <= issued_d;
    end
  end

  assign bus.In_ready    = in_ready;
  assign bus.N_out       = n_out_q;
  assign bus.N_valid_out = n_valid_q;
  assign bus.Busy        = busy_q;
  assign bus.Zero_drop   = zero_drop_q;
  assign bus.Level       = level_q;
  assign bus.Issued_cnt  = issued_q;

endmodule

// File: tb/tb_sum_request_feeder.sv
// Directed bench for sum_request_feeder with a small behavioural sum engine that
// counts down N cycles, accumulating N+(N-1)+...+1, then pulses Sum_valid_in.
module tb_sum_request_feeder;

  logic clk;
  logic rst_n;
  logic eng_pulse;
  logic man_pulse;
  int   n_checks;
  int   n_fail;
  int   issue_q[$];
  int   sum_q[$];
  logic eng_active;
  int   eng_cnt;
  int   eng_acc;

  sum_request_feeder_if #(.AW(2)) bus ();

  sum_request_feeder #(.DEPTH(4), .AW(2)) dut (
    .Clk   (clk),
    .Rst_n (rst_n),
    .bus   (bus)
  );

  assign bus.Sum_valid_in = eng_pulse | man_pulse;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  function automatic int got_n(input int i);
    return (i < issue_q.size()) ? issue_q[i] : -1;
  endfunction

  function automatic int got_s(input int i);
    return (i < sum_q.size()) ? sum_q[i] : -1;
  endfunction

  // Engine model, evaluated on the falling edge so its pulse straddles one rising edge.
  initial begin
    eng_active = 1'b0;
    eng_pulse  = 1'b0;
    eng_cnt    = 0;
    eng_acc    = 0;
    forever begin
      @(negedge clk);
      eng_pulse = 1'b0;
      if (!rst_n) begin
        eng_active = 1'b0;
      end else begin
        if (bus.N_valid_out) begin
          chk("issue_while_engine_busy", {31'd0, eng_active}, 32'd0);
        end
        if (eng_active) begin
          eng_acc += eng_cnt;
          eng_cnt--;
          if (eng_cnt <= 0) begin
            eng_active = 1'b0;
            eng_pulse  = 1'b1;
            sum_q.push_back(eng_acc);
          end
        end
        if (bus.N_valid_out) begin
          issue_q.push_back(int'(bus.N_out));
          eng_active = 1'b1;
          eng_cnt    = int'(bus.N_out);
          eng_acc    = 0;
        end
      end
    end
  end

  task automatic push(input logic [7:0] n);
    bus.In_N     = n;
    bus.In_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.In_valid = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    issue_q.delete();
    sum_q.delete();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(input string tag, input int n_issues, input int budget);
    int i;
    i = 0;
    while (!(issue_q.size() == n_issues && sum_q.size() == n_issues &&
             bus.Busy == 1'b0 && bus.Level == 3'd0) && i < budget) begin
      @(negedge clk);
      i++;
    end
    chk(tag, {31'd0, (i < budget)}, 32'd1);
  endtask

  initial begin
    n_checks     = 0;
    n_fail       = 0;
    rst_n        = 1'b0;
    man_pulse    = 1'b0;
    bus.In_N     = 8'd0;
    bus.In_valid = 1'b0;

    // Reset values
    @(negedge clk);
    chk("rst_in_ready", {31'd0, bus.In_ready}, 32'd0);
    chk("rst_level", {29'd0, bus.Level}, 32'd0);
    chk("rst_busy", {31'd0, bus.Busy}, 32'd0);
    chk("rst_n_valid", {31'd0, bus.N_valid_out}, 32'd0);
    chk("rst_n_out", {24'd0, bus.N_out}, 32'd0);
    chk("rst_issued", {16'd0, bus.Issued_cnt}, 32'd0);
    chk("rst_zero_drop", {31'd0, bus.Zero_drop}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("in_ready_after_release", {31'd0, bus.In_ready}, 32'd1);
    @(posedge clk);
    #1;

    // Test 1: single request, latency and hold behaviour
    push(8'd5);
    @(negedge clk);
    chk("t1_no_issue_yet", {31'd0, bus.N_valid_out}, 32'd0);
    chk("t1_level_1", {29'd0, bus.Level}, 32'd1);
    @(negedge clk);
    chk("t1_issue_pulse", {31'd0, bus.N_valid_out}, 32'd1);
    chk("t1_n_out", {24'd0, bus.N_out}, 32'd5);
    chk("t1_busy", {31'd0, bus.Busy}, 32'd1);
    chk("t1_issued_1", {16'd0, bus.Issued_cnt}, 32'd1);
    chk("t1_level_0", {29'd0, bus.Level}, 32'd0);
    @(negedge clk);
    chk("t1_pulse_one_cycle", {31'd0, bus.N_valid_out}, 32'd0);
    chk("t1_busy_held", {31'd0, bus.Busy}, 32'd1);
    wait_done("t1_done", 1, 200);
    chk("t1_sum", got_s(0), 32'd15);
    chk("t1_n_out_held", {24'd0, bus.N_out}, 32'd5);

    // Test 2: three back-to-back requests from a fresh reset
    do_reset();
    push(8'd3);
    push(8'd4);
    push(8'd10);
    wait_done("t2_done", 3, 500);
    chk("t2_n0", got_n(0), 32'd3);
    chk("t2_n1", got_n(1), 32'd4);
    chk("t2_n2", got_n(2), 32'd10);
    chk("t2_s0", got_s(0), 32'd6);
    chk("t2_s1", got_s(1), 32'd10);
    chk("t2_s2", got_s(2), 32'd55);
    chk("t2_issued_3", {16'd0, bus.Issued_cnt}, 32'd3);

    // Test 3: N=0 is dropped, N=2 behind it still issues
    chk("t3_zero_drop_clear", {31'd0, bus.Zero_drop}, 32'd0);
    push(8'd0);
    push(8'd2);
    wait_done("t3_done", 4, 300);
    chk("t3_zero_drop_set", {31'd0, bus.Zero_drop}, 32'd1);
    chk("t3_count", issue_q.size(), 32'd4);
    chk("t3_n", got_n(3), 32'd2);
    chk("t3_sum", got_s(3), 32'd3);
    chk("t3_issued_4", {16'd0, bus.Issued_cnt}, 32'd4);
    chk("t3_level_0", {29'd0, bus.Level}, 32'd0);

    // Test 4: fill the FIFO behind a long request; the extra word must be refused
    push(8'd200);
    repeat (3) @(negedge clk);
    chk("t4_busy", {31'd0, bus.Busy}, 32'd1);
    @(posedge clk);
    #1;
    push(8'd11);
    push(8'd12);
    push(8'd13);
    push(8'd14);
    @(negedge clk);
    chk("t4_level_full", {29'd0, bus.Level}, 32'd4);
    chk("t4_in_ready_low", {31'd0, bus.In_ready}, 32'd0);
    @(posedge clk);
    #1;
    push(8'd99);
    @(negedge clk);
    chk("t4_level_still_full", {29'd0, bus.Level}, 32'd4);
    wait_done("t4_done", 9, 3000);
    chk("t4_count", issue_q.size(), 32'd9);
    chk("t4_n200", got_n(4), 32'd200);
    chk("t4_n11", got_n(5), 32'd11);
    chk("t4_n12", got_n(6), 32'd12);
    chk("t4_n13", got_n(7), 32'd13);
    chk("t4_n14", got_n(8), 32'd14);
    chk("t4_s200", got_s(4), 32'd20100);
    chk("t4_s14", got_s(8), 32'd105);
    chk("t4_issued_9", {16'd0, bus.Issued_cnt}, 32'd9);

    // Test 5: asynchronous reset while waiting on a result
    push(8'd50);
    repeat (4) @(negedge clk);
    chk("t5_waiting", {31'd0, bus.Busy}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t5_busy_clr", {31'd0, bus.Busy}, 32'd0);
    chk("t5_n_out_clr", {24'd0, bus.N_out}, 32'd0);
    chk("t5_issued_clr", {16'd0, bus.Issued_cnt}, 32'd0);
    chk("t5_zero_drop_clr", {31'd0, bus.Zero_drop}, 32'd0);
    chk("t5_in_ready_low", {31'd0, bus.In_ready}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    issue_q.delete();
    sum_q.delete();
    @(posedge clk);
    #1;
    push(8'd1);
    wait_done("t5_done", 1, 100);
    chk("t5_n", got_n(0), 32'd1);
    chk("t5_sum", got_s(0), 32'd1);
    chk("t5_issued_1", {16'd0, bus.Issued_cnt}, 32'd1);

    // Test 6: stray Sum_valid_in while idle is ignored
    @(negedge clk);
    man_pulse = 1'b1;
    @(negedge clk);
    man_pulse = 1'b0;
    @(negedge clk);
    chk("t6_busy", {31'd0, bus.Busy}, 32'd0);
    chk("t6_n_valid", {31'd0, bus.N_valid_out}, 32'd0);
    chk("t6_issued", {16'd0, bus.Issued_cnt}, 32'd1);
    @(posedge clk);
    #1;
    push(8'd7);
    wait_done("t6_done", 2, 100);
    chk("t6_n", got_n(1), 32'd7);
    chk("t6_sum", got_s(1), 32'd28);
    chk("t6_issued_2", {16'd0, bus.Issued_cnt}, 32'd2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at time %0t, expected completion", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
